// File: rtl/free_list_pkg.sv
// Shared constants and types for the physical-register free list.
package free_list_pkg;

  localparam int unsigned N_WAY      = 2;
  localparam int unsigned N_PHYS_REG = 64;
  localparam int unsigned N_ARCH_REG = 32;
  localparam int unsigned CDB_BITS   = $clog2(N_PHYS_REG);
  localparam int unsigned N_FREE     = N_PHYS_REG - N_ARCH_REG;
  localparam int unsigned PTR_BITS   = $clog2(N_FREE);
  localparam int unsigned CNT_BITS   = $clog2(N_FREE + 1);
  localparam int unsigned AVAIL_BITS = $clog2(N_WAY) + 1;

  typedef logic [CDB_BITS-1:0]   tag_t;
  typedef logic [PTR_BITS-1:0]   fl_ptr_t;
  typedef logic [CNT_BITS-1:0]   fl_cnt_t;
  typedef logic [CNT_BITS:0]     fl_sum_t;
  typedef logic [AVAIL_BITS-1:0] avail_t;

  // Advance a buffer pointer with explicit wrap; depth need not be a power of two.
  // Offsets never exceed N_FREE, so a single conditional subtract suffices.
  function automatic fl_ptr_t ptr_add(fl_ptr_t ptr, fl_cnt_t off);
    fl_sum_t sum;
    sum = fl_sum_t'(ptr) + fl_sum_t'(off);
    if (sum >= fl_sum_t'(N_FREE)) begin
      sum = sum - fl_sum_t'(N_FREE);
    end
    return fl_ptr_t'(sum);
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Retire/dispatch tag interface of the free list.
interface free_list_if;
  import free_list_pkg::*;

  logic   [N_WAY-1:0] retire_valid;
  tag_t   [N_WAY-1:0] retire_told;
  logic   [N_WAY-1:0] dispatch_req;
  tag_t   [N_WAY-1:0] free_tag;
  logic   [N_WAY-1:0] free_valid;
  avail_t             free_avail;
  logic               overflow_err;

  // Master: ROB retire + dispatch side.
  modport master (
    output retire_valid, retire_told, dispatch_req,
    input  free_tag, free_valid, free_avail, overflow_err
  );

  // Slave: the free list itself.
  modport slave (
    input  retire_valid, retire_told, dispatch_req,
    output free_tag, free_valid, free_avail, overflow_err
  );

endinterface

// File: rtl/free_list_compact.sv
// Grants requests in slot order up to an available count and reports each
// granted slot's compacted offset plus the total number granted.
module free_list_compact
  import free_list_pkg::*;
(
  input  logic    [N_WAY-1:0] req,
  input  fl_cnt_t             avail,
  output logic    [N_WAY-1:0] grant,
  output fl_cnt_t [N_WAY-1:0] offset,
  output fl_cnt_t             total
);

  // Prefix count of granted slots; once avail is reached every later request is refused.
  always_comb begin
    fl_cnt_t cnt;
    cnt    = '0;
    grant  = '0;
    offset = '0;
    for (int k = 0; k < N_WAY; k++) begin
      offset[k] = cnt;
      if (req[k] && (cnt < avail)) begin
        grant[k] = 1'b1;
        cnt      = cnt + fl_cnt_t'(1);
      end
    end
    total = cnt;
  end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular buffer of free tags, N_WAY pops to
// dispatch and N_WAY pushes from retire per cycle.
module free_list
  import free_list_pkg::*;
(
  input logic          clock,
  input logic          reset,
  free_list_if.slave   fl
);

  tag_t    entry_q [N_FREE];
  fl_ptr_t head_q, head_d;
  fl_ptr_t tail_q, tail_d;
  fl_cnt_t count_q, count_d;
  logic    overflow_q, overflow_d;

  logic    [N_WAY-1:0] pop_grant;
  fl_cnt_t [N_WAY-1:0] pop_off;
  fl_cnt_t             pop_num;
  logic    [N_WAY-1:0] push_req;
  logic    [N_WAY-1:0] push_grant;
  fl_cnt_t [N_WAY-1:0] push_off;
  fl_cnt_t             push_num;
  fl_cnt_t             push_room;

  free_list_compact u_pop (
    .req    (fl.dispatch_req),
    .avail  (count_q),
    .grant  (pop_grant),
    .offset (pop_off),
    .total  (pop_num)
  );

  free_list_compact u_push (
    .req    (push_req),
    .avail  (push_room),
    .grant  (push_grant),
    .offset (push_off),
    .total  (push_num)
  );

  // Qualify pushes (told 0 means no destination) and derive next pointers/count.
  always_comb begin
    for (int k = 0; k < N_WAY; k++) begin
      push_req[k] = fl.retire_valid[k] && (fl.retire_told[k] != '0);
    end
    // Pops free space before pushes claim it, so a full list can still accept.
    push_room  = fl_cnt_t'(N_FREE) - count_q + pop_num;
    head_d     = ptr_add(head_q, pop_num);
    tail_d     = ptr_add(tail_q, push_num);
    count_d    = count_q - pop_num + push_num;
    overflow_d = overflow_q | (|(push_req & ~push_grant));
  end

  // Grant outputs straight from pre-edge state; forced quiet while in reset.
  always_comb begin
    fl.free_valid = '0;
    fl.free_tag   = '0;
    for (int k = 0; k < N_WAY; k++) begin
      if (pop_grant[k] && !reset) begin
        fl.free_valid[k] = 1'b1;
        fl.free_tag[k]   = entry_q[ptr_add(head_q, pop_off[k])];
      end
    end
    fl.free_avail   = (count_q >= fl_cnt_t'(N_WAY)) ? avail_t'(N_WAY) : avail_t'(count_q);
    fl.overflow_err = overflow_q;
  end

  // Pointer, count and sticky overflow registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= fl_cnt_t'(N_FREE);
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; reset preloads every non-architectural tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_FREE; i++) begin
        entry_q[i] <= tag_t'(N_ARCH_REG + i);
      end
    end else begin
      for (int k = 0; k < N_WAY; k++) begin
        if (push_grant[k]) begin
          entry_q[ptr_add(tail_q, push_off[k])] <= fl.retire_told[k];
        end
      end
    end
  end

endmodule
